mux_bus_arbiter: RTL and testbench

MUX_BUS_ARBITER -- requirements
Module: mux_bus_arbiter

---
 rtl/mux_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_mux_bus_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_bus_arbiter.sv
// mux_bus_arbiter
//   Two-requester arbiter that owns the select/enable pins of an ls74157
//   quad 2:1 mux. Ownership is granted fairly: on a tie, the requester that
//   did not own the path most recently wins. A bounded hold time forces the
//   current owner to yield when the other side is waiting. Every hand-over
//   goes through a one-cycle TURN gap with the mux disabled, so that the two
//   sources never drive y in the same cycle (break-before-make).
//
//   Handshake: req_x is a level request sampled on each rising edge. gnt_x is
//   the registered answer and is visible from the edge that sampled the
//   request. The requester keeps req_x high for as long as it wants the path.
//   Dropping req_x releases the path at the next edge. While gnt_x is high,
//   the path carries requester x.
//
// Parameters
//   HOLD_MAX      maximum consecutive grant cycles before a forced yield to a
//                 waiting requester (1..15)
// Ports
//   clk           single clock; all state changes on the rising edge
//   reset_n       synchronous, active-low reset
//   req_a, req_b  requests from side A (mux input a) and side B (mux input b)
//   mux_select    to ls74157 select: 0 = a, 1 = b
//   mux_enable_n  to ls74157 enable_n: 0 = path on, 1 = y forced to 0000
//   gnt_a, gnt_b  current owner of the path
//   last_grant    most recent owner: 0 = A, 1 = B
//   fsm_state     debug view of the FSM (0 IDLE, 1 GNT_A, 2 GNT_B, 3 TURN)
//   hold_cnt      debug view of the hold counter
module mux_bus_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_a,
  input  logic       req_b,
  output logic       mux_select,
  output logic       mux_enable_n,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       last_grant,
  output logic [1:0] fsm_state,
  output logic [3:0] hold_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2,
    TURN  = 2'd3
  } state_t;

  localparam logic [3:0] HOLD_LIMIT = 4'(HOLD_MAX);

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt_next;
  logic       sel_next;
  logic       last_next;

  assign fsm_state = state;

  // Next state, hold counter and the sticky select/last_grant values.
  always_comb begin
    state_next = state;
    cnt_next   = hold_cnt;
    sel_next   = mux_select;
    last_next  = last_grant;

    case (state)
      IDLE, TURN: begin
        if (req_a && !req_b) begin
          state_next = GNT_A;
        end else if (!req_a && req_b) begin
          state_next = GNT_B;
        end else if (req_a && req_b) begin
          // Tie: the side that did not own the path last goes first.
          state_next = last_grant ? GNT_A : GNT_B;
        end else begin
          state_next = IDLE;
        end
      end
      GNT_A: begin
        if (!req_a || (hold_cnt == HOLD_LIMIT && req_b)) begin
          state_next = TURN;
        end
      end
      GNT_B: begin
        if (!req_b || (hold_cnt == HOLD_LIMIT && req_a)) begin
          state_next = TURN;
        end
      end
      default: state_next = IDLE;
    endcase

    // GNT_A and GNT_B are never adjacent, so any move into a GNT state
    // from somewhere else is a fresh entry.
    case (state_next)
      GNT_A: begin
        if (state != GNT_A) begin
          cnt_next  = 4'd1;
          sel_next  = 1'b0;
          last_next = 1'b0;
        end else if (hold_cnt < HOLD_LIMIT) begin
          cnt_next = hold_cnt + 4'd1;
        end
      end
      GNT_B: begin
        if (state != GNT_B) begin
          cnt_next  = 4'd1;
          sel_next  = 1'b1;
          last_next = 1'b1;
        end else if (hold_cnt < HOLD_LIMIT) begin
          cnt_next = hold_cnt + 4'd1;
        end
      end
      default: cnt_next = 4'd0;
    endcase
  end

  // Outputs are registered from the next-state decode, so a request sampled
  // at an edge shows up as a grant straight after that same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      hold_cnt     <= 4'd0;
      gnt_a        <= 1'b0;
      gnt_b        <= 1'b0;
      mux_enable_n <= 1'b1;
      mux_select   <= 1'b0;
      last_grant   <= 1'b1;
    end else begin
      state        <= state_next;
      hold_cnt     <= cnt_next;
      gnt_a        <= (state_next == GNT_A);
      gnt_b        <= (state_next == GNT_B);
      mux_enable_n <= !((state_next == GNT_A) || (state_next == GNT_B));
      mux_select   <= sel_next;
      last_grant   <= last_next;
    end
  end

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Directed testbench for mux_bus_arbiter. The main instance (HOLD_MAX=4)
// drives an ls74157 model with a=1010 and b=0101. A second instance
// (HOLD_MAX=1) shares the same inputs and is used for the alternation case.
module tb_mux_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;

  logic       mux_select, mux_enable_n, gnt_a, gnt_b, last_grant;
  logic [1:0] fsm_state;
  logic [3:0] hold_cnt;

  logic       sel1, en_n1, gnt_a1, gnt_b1, last1;
  logic [1:0] fsm_state1;
  logic [3:0] hold_cnt1;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  // Observed output word: {gnt_a, gnt_b, mux_enable_n, mux_select, last_grant}
  localparam logic [4:0] O_RST = 5'b00101; // idle right after reset
  localparam logic [4:0] O_A   = 5'b10000; // A owns the path
  localparam logic [4:0] O_B   = 5'b01011; // B owns the path
  localparam logic [4:0] O_TA  = 5'b00100; // gap/idle after A
  localparam logic [4:0] O_TB  = 5'b00111; // gap/idle after B

  localparam logic [3:0] MUX_A = 4'b1010;
  localparam logic [3:0] MUX_B = 4'b0101;

  logic [4:0] obs0, obs1;
  logic [3:0] y;

  assign obs0 = {gnt_a, gnt_b, mux_enable_n, mux_select, last_grant};
  assign obs1 = {gnt_a1, gnt_b1, en_n1, sel1, last1};
  // ls74157 behaviour
  assign y = mux_enable_n ? 4'b0000 : (mux_select ? MUX_B : MUX_A);

  mux_bus_arbiter #(.HOLD_MAX(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .req_a(req_a), .req_b(req_b),
    .mux_select(mux_select), .mux_enable_n(mux_enable_n),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .last_grant(last_grant),
    .fsm_state(fsm_state), .hold_cnt(hold_cnt)
  );

  mux_bus_arbiter #(.HOLD_MAX(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .req_a(req_a), .req_b(req_b),
    .mux_select(sel1), .mux_enable_n(en_n1),
    .gnt_a(gnt_a1), .gnt_b(gnt_b1), .last_grant(last1),
    .fsm_state(fsm_state1), .hold_cnt(hold_cnt1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    req_a   = 1'b0;
    req_b   = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // ---------------- every-cycle invariants ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ((gnt_a && gnt_b) || (mux_enable_n !== ~(gnt_a | gnt_b)) ||
          (gnt_b && !mux_select) || (gnt_a && mux_select)) begin
        errors++;
        $display("FAIL invariant_hm4 t=%0t obs=%b", $time, obs0);
      end
      checks++;
      if ((gnt_a1 && gnt_b1) || (en_n1 !== ~(gnt_a1 | gnt_b1)) ||
          (gnt_b1 && !sel1) || (gnt_a1 && sel1)) begin
        errors++;
        $display("FAIL invariant_hm1 t=%0t obs=%b", $time, obs1);
      end
      checks++;
      if (y !== (gnt_a ? MUX_A : (gnt_b ? MUX_B : 4'b0000))) begin
        errors++;
        $display("FAIL mux_y t=%0t y=%b gnt_a=%b gnt_b=%b", $time, y, gnt_a, gnt_b);
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    req_a   = 1'b1;
    req_b   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      mon_en = 1'b1;
      checks++;
      if (obs0 !== O_RST || hold_cnt !== 4'd0 || fsm_state !== 2'd0) begin
        errors++;
        $display("FAIL reset cyc=%0d obs=%b cnt=%0d st=%0d expected obs=%b cnt=0 st=0",
                 i, obs0, hold_cnt, fsm_state, O_RST);
      end
      checks++;
      if (y !== 4'b0000) begin
        errors++;
        $display("FAIL reset_y got=%b expected=0000", y);
      end
    end
  endtask

  task automatic test_single_a();
    apply_reset();
    tick();
    checks++;
    if (obs0 !== O_RST) begin
      errors++;
      $display("FAIL single_idle got=%b expected=%b", obs0, O_RST);
    end
    req_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs0 !== O_A || y !== MUX_A) begin
        errors++;
        $display("FAIL single_a cyc=%0d obs=%b y=%b expected obs=%b y=%b",
                 i, obs0, y, O_A, MUX_A);
      end
    end
    // Hold counter saturates; with no contention A keeps the path.
    checks++;
    if (hold_cnt !== 4'd4) begin
      errors++;
      $display("FAIL single_sat hold_cnt=%0d expected=4", hold_cnt);
    end
    req_a = 1'b0;
    tick();
    checks++;
    if (obs0 !== O_TA || fsm_state !== 2'd3) begin
      errors++;
      $display("FAIL single_turn obs=%b st=%0d expected obs=%b st=3", obs0, fsm_state, O_TA);
    end
    tick();
    checks++;
    if (obs0 !== O_TA || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL single_idle_after obs=%b st=%0d expected obs=%b st=0", obs0, fsm_state, O_TA);
    end
  endtask

  task automatic test_contention();
    logic [4:0] exp;
    apply_reset();
    req_a = 1'b1;
    req_b = 1'b1;
    // A x4, TURN, B x4, TURN, A x4
    for (int i = 0; i < 14; i++) begin
      tick();
      case (i % 10)
        0, 1, 2, 3: exp = O_A;
        4:          exp = O_TA;
        9:          exp = O_TB;
        default:    exp = O_B;
      endcase
      checks++;
      if (obs0 !== exp) begin
        errors++;
        $display("FAIL contention cyc=%0d obs=%b expected=%b", i, obs0, exp);
      end
    end
  endtask

  task automatic test_drop_to_b();
    apply_reset();
    req_a = 1'b1;
    req_b = 1'b1;
    tick();
    tick();
    checks++;
    if (obs0 !== O_A || hold_cnt !== 4'd2) begin
      errors++;
      $display("FAIL drop_pre obs=%b cnt=%0d expected obs=%b cnt=2", obs0, hold_cnt, O_A);
    end
    req_a = 1'b0;
    tick();
    checks++;
    if (obs0 !== O_TA) begin
      errors++;
      $display("FAIL drop_turn obs=%b expected=%b", obs0, O_TA);
    end
    tick();
    checks++;
    if (obs0 !== O_B || y !== MUX_B) begin
      errors++;
      $display("FAIL drop_b obs=%b y=%b expected obs=%b y=%b", obs0, y, O_B, MUX_B);
    end
  endtask

  task automatic test_reset_mid_grant();
    // Entered in GNT_B from test_drop_to_b
    req_a   = 1'b1;
    req_b   = 1'b1;
    reset_n = 1'b0;
    tick();
    checks++;
    if (obs0 !== O_RST || fsm_state !== 2'd0 || hold_cnt !== 4'd0) begin
      errors++;
      $display("FAIL midgrant_reset obs=%b st=%0d cnt=%0d expected obs=%b st=0 cnt=0",
               obs0, fsm_state, hold_cnt, O_RST);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (obs0 !== O_A) begin
      errors++;
      $display("FAIL midgrant_release obs=%b expected=%b", obs0, O_A);
    end
  endtask

  task automatic test_turn_eval();
    apply_reset();
    req_a = 1'b1;
    tick();
    checks++;
    if (obs0 !== O_A) begin
      errors++;
      $display("FAIL turn_eval_a obs=%b expected=%b", obs0, O_A);
    end
    req_a = 1'b0;
    req_b = 1'b1;
    tick();
    // In TURN: B drops, A returns -> A wins at the TURN edge
    req_a = 1'b1;
    req_b = 1'b0;
    tick();
    checks++;
    if (obs0 !== O_A || hold_cnt !== 4'd1) begin
      errors++;
      $display("FAIL turn_eval_reenter obs=%b cnt=%0d expected obs=%b cnt=1", obs0, hold_cnt, O_A);
    end
    req_a = 1'b0;
    req_b = 1'b1;
    tick();
    // Tie raised during TURN: last owner was A, so B wins
    req_a = 1'b1;
    tick();
    checks++;
    if (obs0 !== O_B) begin
      errors++;
      $display("FAIL turn_eval_tie obs=%b expected=%b", obs0, O_B);
    end
  endtask

  task automatic test_hold1();
    logic [4:0] exp;
    apply_reset();
    req_a = 1'b1;
    req_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      case (i % 4)
        0:       exp = O_A;
        1:       exp = O_TA;
        2:       exp = O_B;
        default: exp = O_TB;
      endcase
      checks++;
      if (obs1 !== exp) begin
        errors++;
        $display("FAIL hold1 cyc=%0d obs=%b expected=%b", i, obs1, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_contention();
    test_drop_to_b();
    test_reset_mid_grant();
    test_turn_eval();
    test_hold1();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "simulation time limit");
  end

endmodule
